// File: rtl/comp_seq_pkg.sv
// Shared types and helpers for the chunk-serial magnitude comparator.
//   state_t  : controller state encoding (IDLE, RUN, DONE)
//   OP_GE/GT : op input encodings (A>=B / A>B)
//   chunks() : number of W-bit slices needed to cover an N-bit operand
package comp_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic OP_GE = 1'b0;
    localparam logic OP_GT = 1'b1;

    function automatic int unsigned chunks(input int unsigned n, input int unsigned w);
        return (n + w - 1) / w;
    endfunction

endpackage

// File: rtl/comp_seq_ctrl_if.sv
// Handshake bundle for comp_seq_ctrl.
//   in_valid/in_ready : operand pair handshake carrying a (N bits), b (M bits), op
//   out_valid/out_ready : result handshake carrying o
//   master : producer of operands / consumer of results
//   slave  : the comparator controller
interface comp_seq_ctrl_if #(
    parameter int unsigned N = 64,
    parameter int unsigned M = N
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [M-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic         o;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, o
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, o
    );
endinterface

// File: rtl/comp_chunk.sv
// One W-bit slice of the comparator carry chain (combinational).
//   full_adder : single-bit full-adder cell
//   comp_chunk : a, b (W bits), ci -> co = carry-out of a + ~b + ci
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module comp_chunk #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic         co
);
    logic [W:0]   c;
    logic [W-1:0] b_n;
    // Only the carry matters for a magnitude compare; sums are left dangling.
    logic [W-1:0] sum_unused;

    assign c[0] = ci;
    assign b_n  = ~b;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b_n[i]),
            .ci (c[i]),
            .s  (sum_unused[i]),
            .co (c[i+1])
        );
    end

    assign co = c[W];
endmodule

// File: rtl/comp_seq_ctrl.sv
// Chunk-serial unsigned magnitude comparator controller.
// Compares an N-bit A against an M-bit B (zero-extended) W bits per cycle,
// LSB slice first, through a single shared comp_chunk.
//   clk, rst : clock, synchronous active-high reset
//   bus      : comp_seq_ctrl_if slave (operand and result handshakes)
//   busy     : high while in RUN or DONE
module comp_seq_ctrl
    import comp_seq_pkg::*;
#(
    parameter int unsigned N = 64,
    parameter int unsigned M = N,
    parameter int unsigned W = 8
) (
    input  logic            clk,
    input  logic            rst,
    comp_seq_ctrl_if.slave  bus,
    output logic            busy
);
    localparam int unsigned CHUNKS = chunks(N, W);
    localparam int unsigned IDXW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int unsigned PADW   = CHUNKS * W;
    localparam logic [IDXW-1:0] LAST = IDXW'(CHUNKS - 1);

    state_t          state;
    logic [PADW-1:0] a_q;
    logic [PADW-1:0] b_q;
    logic [IDXW-1:0] idx;
    logic            carry;
    logic            cout;

    // Operand registers shift right each RUN cycle, so the active slice is
    // always the low W bits; idx only tracks which slice is the last one.
    comp_chunk #(.W(W)) u_chunk (
        .a  (a_q[W-1:0]),
        .b  (b_q[W-1:0]),
        .ci (carry),
        .co (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.o         <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
            idx           <= '0;
            carry         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        a_q          <= PADW'(bus.a);
                        b_q          <= PADW'(bus.b);
                        // Initial carry 1 turns A + ~B into A - B (GE test);
                        // carry 0 makes the final carry mean A > B.
                        carry        <= (bus.op == OP_GE);
                        idx          <= '0;
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    carry <= cout;
                    a_q   <= a_q >> W;
                    b_q   <= b_q >> W;
                    if (idx == LAST) begin
                        idx           <= '0;
                        bus.o         <= cout;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Self-checking bench for comp_seq_ctrl: four DUT configurations
// (64/64/8, 20/12/8, 33/33/32, 8/8/8) share one stimulus bus selected by sel.
module tb_comp_seq_ctrl;
    import comp_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]  sel;
    logic        in_valid;
    logic        op_drv;
    logic        out_ready;
    logic [63:0] a_drv;
    logic [63:0] b_drv;

    int checks = 0;
    int errors = 0;

    int unsigned nw [4] = '{64, 20, 33, 8};
    int unsigned mw [4] = '{64, 12, 33, 8};
    int unsigned ch [4] = '{8, 3, 2, 1};

    logic exp_q [$];
    int unsigned acc_cyc;

    comp_seq_ctrl_if #(.N(64), .M(64)) if0 ();
    comp_seq_ctrl_if #(.N(20), .M(12)) if1 ();
    comp_seq_ctrl_if #(.N(33), .M(33)) if2 ();
    comp_seq_ctrl_if #(.N(8),  .M(8))  if3 ();

    assign if0.in_valid = in_valid && (sel == 2'd0);
    assign if1.in_valid = in_valid && (sel == 2'd1);
    assign if2.in_valid = in_valid && (sel == 2'd2);
    assign if3.in_valid = in_valid && (sel == 2'd3);
    assign if0.a = a_drv;
    assign if0.b = b_drv;
    assign if1.a = a_drv[19:0];
    assign if1.b = b_drv[11:0];
    assign if2.a = a_drv[32:0];
    assign if2.b = b_drv[32:0];
    assign if3.a = a_drv[7:0];
    assign if3.b = b_drv[7:0];
    assign if0.op = op_drv;
    assign if1.op = op_drv;
    assign if2.op = op_drv;
    assign if3.op = op_drv;
    assign if0.out_ready = out_ready;
    assign if1.out_ready = out_ready;
    assign if2.out_ready = out_ready;
    assign if3.out_ready = out_ready;

    logic busy0, busy1, busy2, busy3;

    comp_seq_ctrl #(.N(64), .M(64), .W(8))  u_dut0 (.clk(clk), .rst(rst), .bus(if0), .busy(busy0));
    comp_seq_ctrl #(.N(20), .M(12), .W(8))  u_dut1 (.clk(clk), .rst(rst), .bus(if1), .busy(busy1));
    comp_seq_ctrl #(.N(33), .M(33), .W(32)) u_dut2 (.clk(clk), .rst(rst), .bus(if2), .busy(busy2));
    comp_seq_ctrl #(.N(8),  .M(8),  .W(8))  u_dut3 (.clk(clk), .rst(rst), .bus(if3), .busy(busy3));

    logic cur_in_ready, cur_out_valid, cur_o, cur_busy;
    always_comb begin
        cur_in_ready  = if0.in_ready;
        cur_out_valid = if0.out_valid;
        cur_o         = if0.o;
        cur_busy      = busy0;
        case (sel)
            2'd1: begin cur_in_ready = if1.in_ready; cur_out_valid = if1.out_valid; cur_o = if1.o; cur_busy = busy1; end
            2'd2: begin cur_in_ready = if2.in_ready; cur_out_valid = if2.out_valid; cur_o = if2.o; cur_busy = busy2; end
            2'd3: begin cur_in_ready = if3.in_ready; cur_out_valid = if3.out_valid; cur_o = if3.o; cur_busy = busy3; end
            default: ;
        endcase
    end

    function automatic logic [63:0] mask(input int unsigned n);
        if (n >= 64) return '1;
        return (64'd1 << n) - 64'd1;
    endfunction

    function automatic logic model(input logic [63:0] a, input logic [63:0] b, input logic op);
        return (op == OP_GT) ? (a > b) : (a >= b);
    endfunction

    // Drives one pair; pushes the expected result at the accepting edge.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic op);
        a_drv    = a & mask(nw[sel]);
        b_drv    = b & mask(mw[sel]);
        op_drv   = op;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (cur_in_ready) begin
                exp_q.push_back(model(a_drv, b_drv, op));
                @(posedge clk); #1;
                acc_cyc  = cyc;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; errors++;
        $display("FAIL send_timeout: in_ready=%0b after 100 cycles, required 1", cur_in_ready);
    endtask

    // Waits for a result (out_ready assumed high) and checks it against the queue.
    task automatic recv(input string name, input bit chk_lat);
        logic e;
        for (int i = 0; i < 100; i++) begin
            if (cur_out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s: o=%0b with empty scoreboard", name, cur_o);
                end else begin
                    e = exp_q.pop_front();
                    if (cur_o !== e) begin
                        errors++;
                        $display("FAIL %s: o=%0b required %0b", name, cur_o, e);
                    end
                end
                if (chk_lat) begin
                    checks++;
                    if (cyc - acc_cyc !== ch[sel]) begin
                        errors++;
                        $display("FAIL %s_latency: %0d cycles required %0d", name, cyc - acc_cyc, ch[sel]);
                    end
                end
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        checks++; errors++;
        $display("FAIL %s_timeout: out_valid=%0b after 100 cycles, required 1", name, cur_out_valid);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel = 2'd0;
        a_drv = '0; b_drv = '0; op_drv = OP_GE;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            #1;
            checks++;
            if (cur_in_ready !== 1'b1 || cur_out_valid !== 1'b0 || cur_o !== 1'b0 || cur_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_dut%0d: in_ready=%0b out_valid=%0b o=%0b busy=%0b required 1 0 0 0",
                         k, cur_in_ready, cur_out_valid, cur_o, cur_busy);
            end
        end
        sel = 2'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed_64();
        sel = 2'd0; #1;
        send(64'd5, 64'd5, OP_GE);                                       recv("eq_ge", 1);
        send(64'd5, 64'd5, OP_GT);                                       recv("eq_gt", 1);
        send(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, OP_GE);                     recv("zero_vs_max", 1);
        send(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, OP_GT);   recv("top_slice", 1);
    endtask

    task automatic test_nonmultiple();
        sel = 2'd1; #1;
        send(64'hFFFFF, 64'hFFF, OP_GE);  recv("pad_ge", 1);
        send(64'h00FFE, 64'hFFF, OP_GE);  recv("pad_lt", 1);
        send(64'h01000, 64'hFFF, OP_GT);  recv("pad_gt", 1);
    endtask

    task automatic test_backpressure();
        logic e;
        bit seen;
        sel = 2'd0; #1;
        out_ready = 1'b0;
        send(64'd9, 64'd3, OP_GE);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (cur_out_valid) seen = 1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_wait: out_valid=0 after 20 cycles, required 1");
        end
        a_drv = 64'd1; b_drv = 64'd2; op_drv = OP_GE; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (cur_out_valid !== 1'b1 || cur_o !== 1'b1 || cur_in_ready !== 1'b0 || cur_busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: out_valid=%0b o=%0b in_ready=%0b busy=%0b required 1 1 0 1",
                         cur_out_valid, cur_o, cur_in_ready, cur_busy);
            end
        end
        out_ready = 1'b1;
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
        if (cur_o !== e) begin
            errors++;
            $display("FAIL bp_result: o=%0b required %0b", cur_o, e);
        end
        @(posedge clk); #1;
        checks++;
        if (cur_in_ready !== 1'b1 || cur_out_valid !== 1'b0 || cur_busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: in_ready=%0b out_valid=%0b busy=%0b required 1 0 0",
                     cur_in_ready, cur_out_valid, cur_busy);
        end
        exp_q.push_back(model(a_drv, b_drv, op_drv));
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        checks++;
        if (cur_in_ready !== 1'b0 || cur_busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept: in_ready=%0b busy=%0b required 0 1", cur_in_ready, cur_busy);
        end
        recv("bp_new", 1);
    endtask

    task automatic test_back_to_back(input logic [1:0] s);
        int accepts, results;
        int unsigned last_acc;
        bit took;
        logic e;
        sel = s; #1;
        out_ready = 1'b1;
        accepts = 0; results = 0; last_acc = 0;
        a_drv = {$urandom, $urandom} & mask(nw[sel]);
        b_drv = {$urandom, $urandom} & mask(mw[sel]);
        op_drv = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        for (int i = 0; i < 200 && (accepts < 3 || results < 3); i++) begin
            took = 0;
            if (cur_out_valid) begin
                checks++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
                if (cur_o !== e) begin
                    errors++;
                    $display("FAIL b2b_result: o=%0b required %0b", cur_o, e);
                end
                results++;
            end
            if (cur_in_ready && in_valid) begin
                exp_q.push_back(model(a_drv, b_drv, op_drv));
                if (accepts > 0) begin
                    checks++;
                    if (cyc + 1 - last_acc !== ch[sel] + 2) begin
                        errors++;
                        $display("FAIL b2b_interval: %0d cycles required %0d", cyc + 1 - last_acc, ch[sel] + 2);
                    end
                end
                last_acc = cyc + 1;
                accepts++;
                took = 1;
            end
            @(posedge clk); #1;
            if (took) begin
                if (accepts >= 3) in_valid = 1'b0;
                a_drv = {$urandom, $urandom} & mask(nw[sel]);
                b_drv = {$urandom, $urandom} & mask(mw[sel]);
                op_drv = 1'($urandom_range(0, 1));
            end
        end
        in_valid = 1'b0;
        if (accepts < 3 || results < 3) begin
            checks++; errors++;
            $display("FAIL b2b_timeout: accepts=%0d results=%0d required 3 3", accepts, results);
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        sel = 2'd0; #1;
        send(64'd7, 64'd3, OP_GE);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        checks++;
        if (cur_in_ready !== 1'b1 || cur_busy !== 1'b0 || cur_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: in_ready=%0b busy=%0b out_valid=%0b required 1 0 0",
                     cur_in_ready, cur_busy, cur_out_valid);
        end
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (cur_out_valid) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_result: out_valid seen=1 required 0");
        end
    endtask

    task automatic test_random(input logic [1:0] s);
        logic [63:0] a, b;
        sel = s; #1;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b = a;
            send(a, b, 1'($urandom_range(0, 1)));
            recv("random", 0);
        end
    endtask

    initial begin
        test_reset();
        test_directed_64();
        test_nonmultiple();
        test_backpressure();
        test_back_to_back(2'd0);
        test_back_to_back(2'd3);
        test_reset_mid_run();
        test_random(2'd0);
        test_random(2'd2);
        test_random(2'd3);
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_leftover: %0d entries required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
